// File: rtl/vu_vmu_pkg.sv
// Shared VMU types: memory access type encodings and reorder-queue limits.
package vu_vmu_pkg;

  typedef enum logic [2:0] {
    MT_B  = 3'b000,
    MT_H  = 3'b001,
    MT_W  = 3'b010,
    MT_D  = 3'b011,
    MT_BU = 3'b100,
    MT_HU = 3'b101,
    MT_WU = 3'b110
  } mem_typ_e;

  localparam int unsigned ROQ_DEPTH_MAX = 256;

endpackage

// File: rtl/vu_vmu_load_align.sv
// Combinational load alignment: shift a 64b D$ word right by the byte offset, then sign/zero extend per access type.
module vu_vmu_load_align
  import vu_vmu_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        lsb_i,
  input  mem_typ_e          typ_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] shifted;

  assign shifted = data_i >> {lsb_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (typ_i)
      MT_B:    data_o = {{(DATA_W-8){shifted[7]}},   shifted[7:0]};
      MT_H:    data_o = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      MT_W:    data_o = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      MT_BU:   data_o = {{(DATA_W-8){1'b0}},         shifted[7:0]};
      MT_HU:   data_o = {{(DATA_W-16){1'b0}},        shifted[15:0]};
      MT_WU:   data_o = {{(DATA_W-32){1'b0}},        shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/vu_vmu_roq_align.sv
// VMU load reorder queue: in-order tag allocation, out-of-order aligned fills, in-order dequeue.
// Optional ROQ_BYPASS_EN: a legal response to an empty head is forwarded to the dequeue port the same cycle.
module vu_vmu_roq_align
  import vu_vmu_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [TAG_W-1:0]  tag_deq_bits,
  output logic              tag_deq_val,
  input  logic              tag_deq_rdy,
  input  logic [2:0]        tag_deq_typ,
  input  logic              resp_val,
  input  logic [TAG_W-1:0]  resp_tag,
  input  logic [2:0]        resp_lsb,
  input  logic [DATA_W-1:0] resp_data,
  output logic [DATA_W-1:0] data_deq_bits,
  output logic              data_deq_val,
  input  logic              data_deq_rdy,
  output logic [TAG_W:0]    count,
  output logic              resp_err
);

  logic [TAG_W:0]    head_q, head_d;
  logic [TAG_W:0]    tail_q, tail_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  mem_typ_e          typ_q  [DEPTH];

  logic [TAG_W-1:0]  head_idx, tail_idx, resp_off;
  logic              full, alloc, deq;
  logic              resp_alloc, resp_legal, resp_wr, bypass;
  logic [DATA_W-1:0] resp_aligned;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign count    = tail_q - head_q;
  assign full     = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

  assign tag_deq_val  = !full;
  assign tag_deq_bits = tail_idx;
  assign alloc        = tag_deq_val & tag_deq_rdy;

  // A tag is allocated iff its distance from head (mod DEPTH) is below the occupancy.
  assign resp_off   = resp_tag - head_idx;
  assign resp_alloc = {1'b0, resp_off} < count;
  assign resp_legal = resp_val & resp_alloc & ~valid_q[resp_tag];

  vu_vmu_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .data_i (resp_data),
    .lsb_i  (resp_lsb),
    .typ_i  (typ_q[resp_tag]),
    .data_o (resp_aligned)
  );

`ifdef ROQ_BYPASS_EN
  assign bypass = resp_legal && (resp_tag == head_idx);
`else
  assign bypass = 1'b0;
`endif

  assign data_deq_val  = valid_q[head_idx] | bypass;
  assign data_deq_bits = bypass ? resp_aligned : data_q[head_idx];
  assign deq           = data_deq_val & data_deq_rdy;
  // A bypassed entry that is popped immediately is never marked valid.
  assign resp_wr       = resp_legal & ~(bypass & data_deq_rdy);

  always_comb begin
    head_d  = head_q + {{TAG_W{1'b0}}, deq};
    tail_d  = tail_q + {{TAG_W{1'b0}}, alloc};
    err_d   = err_q | (resp_val & ~resp_legal);
    valid_d = valid_q;
    if (deq)     valid_d[head_idx] = 1'b0;
    if (resp_wr) valid_d[resp_tag] = 1'b1;
    if (alloc)   valid_d[tail_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        typ_q[i]  <= MT_B;
      end
    end else begin
      if (alloc)   typ_q[tail_idx]  <= mem_typ_e'(tag_deq_typ);
      if (resp_wr) data_q[resp_tag] <= resp_aligned;
    end
  end

  assign resp_err = err_q;

endmodule

// File: tb/tb_vu_vmu_roq_align.sv
// Self-checking bench for vu_vmu_roq_align: directed sequences, an alignment vector table and a randomized run against a queue model.
module tb_vu_vmu_roq_align;
  import vu_vmu_pkg::*;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TAG_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [TAG_W-1:0]  tag_deq_bits;
  logic              tag_deq_val;
  logic              tag_deq_rdy;
  logic [2:0]        tag_deq_typ;
  logic              resp_val;
  logic [TAG_W-1:0]  resp_tag;
  logic [2:0]        resp_lsb;
  logic [DATA_W-1:0] resp_data;
  logic [DATA_W-1:0] data_deq_bits;
  logic              data_deq_val;
  logic              data_deq_rdy;
  logic [TAG_W:0]    count;
  logic              resp_err;

  always #5 clk = ~clk;

  vu_vmu_roq_align #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tag_deq_bits  (tag_deq_bits),
    .tag_deq_val   (tag_deq_val),
    .tag_deq_rdy   (tag_deq_rdy),
    .tag_deq_typ   (tag_deq_typ),
    .resp_val      (resp_val),
    .resp_tag      (resp_tag),
    .resp_lsb      (resp_lsb),
    .resp_data     (resp_data),
    .data_deq_bits (data_deq_bits),
    .data_deq_val  (data_deq_val),
    .data_deq_rdy  (data_deq_rdy),
    .count         (count),
    .resp_err      (resp_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  typ;
    logic [2:0]  lsb;
    logic [63:0] data;
    logic [63:0] exp;
  } align_vec_t;

  typedef struct {
    int unsigned tag;
    int unsigned typ;
    bit          filled;
    logic [63:0] data;
  } ent_t;

  align_vec_t  vecs [12];
  ent_t        q [$];
  int unsigned unf [$];
  int unsigned m_next;
  int unsigned exp_tag;
  int unsigned pick;
  int unsigned sz;
  bit          m_err;
  bit          pre_val;
  bit          hit;
  logic [63:0] exp_bits;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tag_deq_rdy  = 1'b0;
    resp_val     = 1'b0;
    data_deq_rdy = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic alloc_one(input logic [2:0] typ);
    tag_deq_typ = typ;
    tag_deq_rdy = 1'b1;
    tick();
    tag_deq_rdy = 1'b0;
  endtask

  task automatic respond(input int unsigned tag, input logic [2:0] lsb, input logic [63:0] d);
    resp_val  = 1'b1;
    resp_tag  = TAG_W'(tag);
    resp_lsb  = lsb;
    resp_data = d;
    tick();
    resp_val  = 1'b0;
  endtask

  // Reference alignment: arithmetic on field width rather than a per-type case.
  function automatic logic [63:0] ref_align(input logic [63:0] d, input int unsigned lsb, input int unsigned typ);
    int unsigned bits;
    logic [63:0] v;
    logic [63:0] keep;
    bits = 8 << (typ % 4);
    v    = d >> (8 * lsb);
    if (bits == 64) return v;
    keep = (64'd1 << bits) - 64'd1;
    v    = v & keep;
    if (typ < 4 && v[bits-1]) v = v | ~keep;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{MT_B,  3'd5, 64'h0000_80AA_0000_0000, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{MT_BU, 3'd5, 64'h0000_80AA_0000_0000, 64'h0000_0000_0000_0080};
    vecs[2]  = '{MT_H,  3'd2, 64'h1122_3344_8899_AABB, 64'hFFFF_FFFF_FFFF_8899};
    vecs[3]  = '{MT_HU, 3'd2, 64'h1122_3344_8899_AABB, 64'h0000_0000_0000_8899};
    vecs[4]  = '{MT_W,  3'd4, 64'h1122_3344_8899_AABB, 64'h0000_0000_1122_3344};
    vecs[5]  = '{MT_W,  3'd0, 64'h1122_3344_8899_AABB, 64'hFFFF_FFFF_8899_AABB};
    vecs[6]  = '{MT_WU, 3'd0, 64'h1122_3344_8899_AABB, 64'h0000_0000_8899_AABB};
    vecs[7]  = '{MT_D,  3'd0, 64'h1122_3344_8899_AABB, 64'h1122_3344_8899_AABB};
    vecs[8]  = '{MT_D,  3'd3, 64'h1122_3344_8899_AABB, 64'h0000_0011_2233_4488};
    vecs[9]  = '{MT_B,  3'd7, 64'h1122_3344_8899_AABB, 64'h0000_0000_0000_0011};
    vecs[10] = '{MT_H,  3'd6, 64'hFEDC_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FEDC};
    vecs[11] = '{MT_BU, 3'd1, 64'h0000_0000_0000_FF00, 64'h0000_0000_0000_00FF};

    tag_deq_typ = MT_D;
    resp_tag    = '0;
    resp_lsb    = '0;
    resp_data   = '0;
    do_reset();

    // Reset state
    chk("rst_tag_val",  tag_deq_val,   1);
    chk("rst_tag_bits", tag_deq_bits,  0);
    chk("rst_count",    count,         0);
    chk("rst_data_val", data_deq_val,  0);
    chk("rst_data_bits", data_deq_bits, 0);
    chk("rst_err",      resp_err,      0);

    // Allocate four tags
    for (int i = 0; i < 4; i++) begin
      chk("alloc_tag", tag_deq_bits, i);
      alloc_one(MT_D);
    end
    chk("alloc_count", count, 4);
    chk("alloc_data_val", data_deq_val, 0);

    // Out-of-order responses, in-order dequeue
    respond(3, 3'd0, 64'hC0DE_0000_0000_0003);
    chk("ooo_val_after3", data_deq_val, 0);
    respond(1, 3'd0, 64'hC0DE_0000_0000_0001);
    chk("ooo_val_after1", data_deq_val, 0);
    respond(0, 3'd0, 64'hC0DE_0000_0000_0000);
    chk("ooo_val_after0", data_deq_val, 1);
    respond(2, 3'd0, 64'hC0DE_0000_0000_0002);
    for (int i = 0; i < 4; i++) begin
      chk("ooo_deq_val", data_deq_val, 1);
      chk("ooo_deq_bits", data_deq_bits, 64'hC0DE_0000_0000_0000 | 64'(i));
      data_deq_rdy = 1'b1;
      tick();
      data_deq_rdy = 1'b0;
    end
    chk("ooo_count_empty", count, 0);
    chk("ooo_val_empty", data_deq_val, 0);
    chk("ooo_err", resp_err, 0);

    // Alignment table
    exp_tag = 4;
    for (int i = 0; i < 12; i++) begin
      chk("vec_tag", tag_deq_bits, exp_tag);
      alloc_one(vecs[i].typ);
      respond(exp_tag, vecs[i].lsb, vecs[i].data);
      chk("vec_val", data_deq_val, 1);
      chk("vec_bits", data_deq_bits, vecs[i].exp);
      data_deq_rdy = 1'b1;
      tick();
      data_deq_rdy = 1'b0;
      exp_tag = (exp_tag + 1) % DEPTH;
    end
    chk("vec_err", resp_err, 0);

    // Fill to full, blocked alloc, simultaneous deq+alloc while full, wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("fill_tag", tag_deq_bits, i);
      alloc_one(MT_D);
    end
    chk("full_val", tag_deq_val, 0);
    chk("full_count", count, 16);
    alloc_one(MT_D);
    chk("full_blocked_count", count, 16);
    respond(0, 3'd0, 64'h0123_4567_89AB_CDEF);
    chk("full_head_val", data_deq_val, 1);
    data_deq_rdy = 1'b1;
    tag_deq_rdy  = 1'b1;
    tick();
    idle();
    chk("full_deq_count", count, 15);
    chk("full_deq_tag_val", tag_deq_val, 1);
    chk("wrap_tag", tag_deq_bits, 0);
    alloc_one(MT_D);
    chk("wrap_count", count, 16);
    chk("wrap_full", tag_deq_val, 0);

    // Error: unallocated, pre-reset tag, duplicate
    do_reset();
    alloc_one(MT_D);
    alloc_one(MT_D);
    respond(7, 3'd0, 64'hDEAD);
    chk("unalloc_err", resp_err, 1);
    chk("unalloc_val", data_deq_val, 0);
    chk("unalloc_count", count, 2);
    tick();
    chk("unalloc_sticky", resp_err, 1);
    do_reset();
    chk("err_cleared", resp_err, 0);
    respond(1, 3'd0, 64'hBEEF);
    chk("prereset_err", resp_err, 1);
    do_reset();
    alloc_one(MT_D);
    respond(0, 3'd0, 64'hAAAA_0000_0000_5555);
    chk("dup_first_err", resp_err, 0);
    chk("dup_first_bits", data_deq_bits, 64'hAAAA_0000_0000_5555);
    respond(0, 3'd0, 64'h1111_1111_1111_1111);
    chk("dup_err", resp_err, 1);
    chk("dup_bits_kept", data_deq_bits, 64'hAAAA_0000_0000_5555);
    data_deq_rdy = 1'b1;
    tick();
    idle();
    chk("dup_count", count, 0);
    chk("dup_sticky", resp_err, 1);

`ifdef ROQ_BYPASS_EN
    // Same-cycle forwarding of a response to the head
    do_reset();
    alloc_one(MT_B);
    resp_val     = 1'b1;
    resp_tag     = '0;
    resp_lsb     = 3'd5;
    resp_data    = 64'h0000_80AA_0000_0000;
    data_deq_rdy = 1'b1;
    #1;
    chk("byp_val", data_deq_val, 1);
    chk("byp_bits", data_deq_bits, 64'hFFFF_FFFF_FFFF_FF80);
    chk("byp_count_before", count, 1);
    tick();
    idle();
    chk("byp_count_after", count, 0);
    chk("byp_val_after", data_deq_val, 0);
    chk("byp_err", resp_err, 0);
`endif

    // Randomized run against the queue model
    do_reset();
    q.delete();
    m_next = 0;
    m_err  = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tag_deq_rdy  = ($urandom % 3) != 0;
      tag_deq_typ  = 3'($urandom % 7);
      data_deq_rdy = ($urandom % 4) < (1 + (cyc / 500) % 3);
      resp_val     = 1'b0;
      resp_tag     = '0;
      resp_lsb     = 3'($urandom % 8);
      resp_data    = {$urandom, $urandom};
      unf.delete();
      foreach (q[k]) if (!q[k].filled) unf.push_back(k);
      pick = 0;
      if (unf.size() > 0 && ($urandom % 2) == 1) begin
        pick     = unf[$urandom % unf.size()];
        resp_val = 1'b1;
        resp_tag = TAG_W'(q[pick].tag);
      end
      pre_val = (q.size() > 0) && q[0].filled;
      hit     = 1'b0;
`ifdef ROQ_BYPASS_EN
      hit = resp_val && (pick == 0);
`endif
      #1;
      chk("rnd_tag_val",  tag_deq_val,  q.size() < DEPTH);
      chk("rnd_tag_bits", tag_deq_bits, m_next);
      chk("rnd_count",    count,        q.size());
      chk("rnd_data_val", data_deq_val, pre_val | hit);
      if (pre_val || hit) begin
        exp_bits = hit ? ref_align(resp_data, resp_lsb, q[0].typ) : q[0].data;
        chk("rnd_data_bits", data_deq_bits, exp_bits);
      end
      chk("rnd_err", resp_err, m_err);
      @(posedge clk);
      sz = q.size();
      if (resp_val && !(hit && data_deq_rdy)) begin
        q[pick].filled = 1'b1;
        q[pick].data   = ref_align(resp_data, resp_lsb, q[pick].typ);
      end
      if ((pre_val || hit) && data_deq_rdy) void'(q.pop_front());
      if (sz < DEPTH && tag_deq_rdy) begin
        q.push_back('{tag: m_next, typ: tag_deq_typ, filled: 1'b0, data: '0});
        m_next = (m_next + 1) % DEPTH;
      end
      #1;
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
